// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush bubbles and bubble counter
// Optional load-use detection enabled by defining HAZARD_DETECT_EN.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic [1:0]       id_RegDst,
  input  logic             id_ALUSrc,
  input  logic             id_MemRead,
  input  logic             id_RegWrite,
  input  logic             id_MemWrite,
  input  logic             id_ShamtSrc,
  input  logic             id_Branch,
  input  logic [1:0]       id_DatatoReg,
  input  logic [4:0]       id_ALUCtrl,
  input  logic [DW-1:0]    id_pc4,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm_ext,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_shamt,
  output logic [1:0]       ex_RegDst,
  output logic             ex_ALUSrc,
  output logic             ex_MemRead,
  output logic             ex_RegWrite,
  output logic             ex_MemWrite,
  output logic             ex_ShamtSrc,
  output logic             ex_Branch,
  output logic [1:0]       ex_DatatoReg,
  output logic [4:0]       ex_ALUCtrl,
  output logic [DW-1:0]    ex_pc4,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm_ext,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_shamt,
  output logic             ex_valid,
  output logic             stall_o,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int PW = 2 + 6 + 2 + 5 + 4 * DW + 20;

  logic [PW-1:0]    id_word;
  logic [PW-1:0]    ex_q, ex_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             haz;
  logic             bump;

  assign id_word = {id_RegDst, id_ALUSrc, id_MemRead, id_RegWrite, id_MemWrite,
                    id_ShamtSrc, id_Branch, id_DatatoReg, id_ALUCtrl,
                    id_pc4, id_rs_data, id_rt_data, id_imm_ext,
                    id_rs, id_rt, id_rd, id_shamt};

  assign {ex_RegDst, ex_ALUSrc, ex_MemRead, ex_RegWrite, ex_MemWrite,
          ex_ShamtSrc, ex_Branch, ex_DatatoReg, ex_ALUCtrl,
          ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext,
          ex_rs, ex_rt, ex_rd, ex_shamt} = ex_q;

  assign ex_valid   = valid_q;
  assign bubble_cnt = cnt_q;

`ifdef HAZARD_DETECT_EN
  // A load in EX whose destination feeds the instruction now in ID must wait one cycle.
  assign haz = valid_q & ex_MemRead & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
`else
  assign haz = 1'b0;
`endif

  assign stall_o = haz & ~flush_i;

  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    bump    = 1'b0;
    if (!hold_i) begin
      if (flush_i || haz) begin
        ex_d    = '0;
        valid_d = 1'b0;
        bump    = 1'b1;
      end else begin
        ex_d    = id_word;
        valid_d = 1'b1;
      end
    end
    if (bump && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed bench for id_ex_stage with cycle-level reference model
module tb_id_ex_stage;

`ifdef HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  localparam int H = HZ ? 1 : 0;

  typedef struct packed {
    logic [1:0]  RegDst;
    logic        ALUSrc, MemRead, RegWrite, MemWrite, ShamtSrc, Branch;
    logic [1:0]  DatatoReg;
    logic [4:0]  ALUCtrl;
    logic [31:0] pc4, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, shamt;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic flush = 1'b0;
  instr_t id = '0;

  logic [1:0]  ex_RegDst, ex_DatatoReg;
  logic        ex_ALUSrc, ex_MemRead, ex_RegWrite, ex_MemWrite, ex_ShamtSrc, ex_Branch;
  logic [4:0]  ex_ALUCtrl, ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic        ex_valid, stall;
  logic [15:0] cnt;
  logic [1:0]  ex2_RegDst, ex2_DatatoReg;
  logic        ex2_ALUSrc, ex2_MemRead, ex2_RegWrite, ex2_MemWrite, ex2_ShamtSrc, ex2_Branch;
  logic [4:0]  ex2_ALUCtrl, ex2_rs, ex2_rt, ex2_rd, ex2_shamt;
  logic [31:0] ex2_pc4, ex2_rs_data, ex2_rt_data, ex2_imm_ext;
  logic        ex2_valid, stall2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold), .flush_i(flush),
    .id_RegDst(id.RegDst), .id_ALUSrc(id.ALUSrc), .id_MemRead(id.MemRead),
    .id_RegWrite(id.RegWrite), .id_MemWrite(id.MemWrite), .id_ShamtSrc(id.ShamtSrc),
    .id_Branch(id.Branch), .id_DatatoReg(id.DatatoReg), .id_ALUCtrl(id.ALUCtrl),
    .id_pc4(id.pc4), .id_rs_data(id.rs_data), .id_rt_data(id.rt_data), .id_imm_ext(id.imm),
    .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd), .id_shamt(id.shamt),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_ShamtSrc(ex_ShamtSrc),
    .ex_Branch(ex_Branch), .ex_DatatoReg(ex_DatatoReg), .ex_ALUCtrl(ex_ALUCtrl),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_valid(ex_valid), .stall_o(stall), .bubble_cnt(cnt)
  );

  id_ex_stage #(.DW(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hold_i(hold), .flush_i(flush),
    .id_RegDst(id.RegDst), .id_ALUSrc(id.ALUSrc), .id_MemRead(id.MemRead),
    .id_RegWrite(id.RegWrite), .id_MemWrite(id.MemWrite), .id_ShamtSrc(id.ShamtSrc),
    .id_Branch(id.Branch), .id_DatatoReg(id.DatatoReg), .id_ALUCtrl(id.ALUCtrl),
    .id_pc4(id.pc4), .id_rs_data(id.rs_data), .id_rt_data(id.rt_data), .id_imm_ext(id.imm),
    .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd), .id_shamt(id.shamt),
    .ex_RegDst(ex2_RegDst), .ex_ALUSrc(ex2_ALUSrc), .ex_MemRead(ex2_MemRead),
    .ex_RegWrite(ex2_RegWrite), .ex_MemWrite(ex2_MemWrite), .ex_ShamtSrc(ex2_ShamtSrc),
    .ex_Branch(ex2_Branch), .ex_DatatoReg(ex2_DatatoReg), .ex_ALUCtrl(ex2_ALUCtrl),
    .ex_pc4(ex2_pc4), .ex_rs_data(ex2_rs_data), .ex_rt_data(ex2_rt_data), .ex_imm_ext(ex2_imm_ext),
    .ex_rs(ex2_rs), .ex_rt(ex2_rt), .ex_rd(ex2_rd), .ex_shamt(ex2_shamt),
    .ex_valid(ex2_valid), .stall_o(stall2), .bubble_cnt(cnt2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the instruction EX should hold, and counts of bubbles.
  instr_t m_ex;
  logic   m_valid;
  int     m_cnt, m_cnt2;
  logic   m_haz;

  always_comb
    m_haz = HZ && m_valid && m_ex.MemRead && (m_ex.rt != 5'd0) &&
            ((m_ex.rt == id.rs) || (m_ex.rt == id.rt));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex <= '0; m_valid <= 1'b0; m_cnt <= 0; m_cnt2 <= 0;
    end else if (!hold) begin
      if (flush || m_haz) begin
        m_ex <= '0; m_valid <= 1'b0;
        m_cnt  <= (m_cnt  >= 65535) ? 65535 : m_cnt + 1;
        m_cnt2 <= (m_cnt2 >= 3) ? 3 : m_cnt2 + 1;
      end else begin
        m_ex <= id; m_valid <= 1'b1;
      end
    end
  end

  instr_t d1, d2;
  always_comb begin
    d1 = {ex_RegDst, ex_ALUSrc, ex_MemRead, ex_RegWrite, ex_MemWrite, ex_ShamtSrc, ex_Branch,
          ex_DatatoReg, ex_ALUCtrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext,
          ex_rs, ex_rt, ex_rd, ex_shamt};
    d2 = {ex2_RegDst, ex2_ALUSrc, ex2_MemRead, ex2_RegWrite, ex2_MemWrite, ex2_ShamtSrc, ex2_Branch,
          ex2_DatatoReg, ex2_ALUCtrl, ex2_pc4, ex2_rs_data, ex2_rt_data, ex2_imm_ext,
          ex2_rs, ex2_rt, ex2_rd, ex2_shamt};
  end

  always @(negedge clk) begin
    chk("model_ex", {d1, ex_valid}, {m_ex, m_valid});
    chk("model_ex2", {d2, ex2_valid}, {m_ex, m_valid});
    chk("model_stall", {stall, stall2}, {2{m_haz && !flush}});
    chk("model_cnt", cnt, m_cnt[15:0]);
    chk("model_cnt2", cnt2, m_cnt2[1:0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t addu(input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = '0;
    i.RegDst = 2'b01; i.RegWrite = 1'b1; i.ALUCtrl = 5'd2;
    i.pc4 = pc4; i.rs = rs; i.rt = rt; i.rd = 5'd3;
    i.rs_data = 32'h1111_0000 + {27'd0, rs}; i.rt_data = 32'h2222_0000 + {27'd0, rt};
    return i;
  endfunction

  function automatic instr_t lw(input logic [31:0] pc4, input logic [4:0] rt);
    instr_t i = '0;
    i.ALUSrc = 1'b1; i.MemRead = 1'b1; i.RegWrite = 1'b1; i.DatatoReg = 2'b01;
    i.pc4 = pc4; i.rs = 5'd29; i.rt = rt; i.imm = 32'h0000_0010; i.rs_data = 32'h0000_1000;
    return i;
  endfunction

  initial begin
    id = '0;
    repeat (2) step();
    chk("reset_state", {ex_valid, cnt, stall, ex_pc4}, 0);
    rst_n = 1'b1;

    // plain flow
    id = addu(32'h4, 5'd1, 5'd2);
    step();
    chk("addu_load", {ex_RegWrite, ex_RegDst, ex_pc4, ex_valid, cnt, stall}, {1'b1, 2'b01, 32'h4, 1'b1, 16'd0, 1'b0});

    // load-use
    id = lw(32'h8, 5'd8);
    step();
    id = addu(32'hC, 5'd8, 5'd2);
    #1;
    chk("loaduse_stall", stall, H);
    step();
    chk("loaduse_bubble", {ex_valid, cnt}, {!HZ, 16'(H)});
    chk("loaduse_after", stall, 1'b0);
    step();
    chk("loaduse_addu", {ex_valid, ex_pc4}, {1'b1, 32'hC});

    // no false hazard
    id = lw(32'h10, 5'd0);
    step();
    id = addu(32'h14, 5'd0, 5'd0);
    #1;
    chk("rt0_nostall", stall, 1'b0);
    step();
    id = lw(32'h18, 5'd8);
    step();
    id = addu(32'h1C, 5'd9, 5'd10);
    #1;
    chk("diffreg_nostall", stall, 1'b0);
    step();
    chk("diffreg_load", {ex_valid, ex_pc4, cnt}, {1'b1, 32'h1C, 16'(H)});

    // flush beats hazard
    id = lw(32'h20, 5'd8);
    step();
    id = addu(32'h24, 5'd3, 5'd8);
    flush = 1'b1;
    #1;
    chk("flush_haz_stall", stall, 1'b0);
    step();
    flush = 1'b0;
    chk("flush_haz_cnt", {ex_valid, cnt}, {1'b0, 16'(H + 1)});

    // hold
    id = addu(32'h40, 5'd4, 5'd5);
    step();
    hold = 1'b1; flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id = addu(32'h100 + 32'(k), 5'd6, 5'd7);
      step();
    end
    chk("hold_frozen", {ex_valid, ex_pc4, cnt}, {1'b1, 32'h40, 16'(H + 1)});
    hold = 1'b0;
    step();
    flush = 1'b0;
    chk("hold_release_flush", {ex_valid, ex_pc4, cnt}, {1'b0, 32'h0, 16'(H + 2)});

    // saturation
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    flush = 1'b1;
    repeat (5) step();
    flush = 1'b0;
    chk("sat_cnt2", cnt2, 2'd3);
    chk("sat_cnt16", cnt, 16'd5);

    // async reset while a stall is pending
    id = lw(32'h50, 5'd8);
    step();
    id = addu(32'h54, 5'd8, 5'd1);
    #1;
    chk("pre_reset_stall", stall, H);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {ex_valid, ex_MemRead, ex_rt, ex_pc4, cnt, stall}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_load", {ex_valid, ex_pc4}, {1'b1, 32'h54});
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the pipelined MIPS core: captures the decoded control word from the instruction decoder plus ID-stage operands on each clock and presents them to EX. Also detects load-use hazards, stalls IF/ID, and inserts bubbles on hazard or branch/jump flush. A saturating counter records inserted bubbles for debug.

## Interface
Parameters:
- DW, 32, datapath width (PC+4, register operands, extended immediate).
- CNT_W, 16, width of bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hold_i  in  1  freeze this stage; all state retained.
- flush_i  in  1  squash the ID instruction; load a bubble.
- id_RegDst  in  2  decoder RegDst.
- id_ALUSrc, id_MemRead, id_RegWrite, id_MemWrite, id_ShamtSrc, id_Branch  in  1 each  decoder controls.
- id_DatatoReg  in  2  decoder DatatoReg.
- id_ALUCtrl  in  5  decoder ALU op.
- id_pc4, id_rs_data, id_rt_data, id_imm_ext  in  DW each  ID operands.
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields.
- ex_* (one per id_* input above)  out  same widths  registered copies.
- ex_valid  out  1  1 = ex_* holds a real instruction, 0 = bubble.
- stall_o  out  1  combinational; freeze PC and IF/ID this cycle.
- bubble_cnt  out  CNT_W  bubbles inserted since reset.

## Operation
- Bubble: all control outputs (RegDst, ALUSrc, MemRead, RegWrite, MemWrite, DatatoReg, ALUCtrl, ShamtSrc, Branch) = 0, ex_valid = 0; data/field outputs also 0.
- Hazard: haz = ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- stall_o = haz & ~flush_i.
- Per-edge priority, highest first:
  1. hold_i=1: all outputs and bubble_cnt retained.
  2. flush_i=1: load bubble; bubble_cnt += 1.
  3. haz=1: load bubble; bubble_cnt += 1. Upstream sees stall_o and re-presents the same ID instruction next cycle.
  4. Otherwise: load all id_* into ex_*; ex_valid = 1.
- bubble_cnt saturates at 2^CNT_W-1; it never wraps.
- During hold_i, stall_o is still computed from the frozen ex_* contents. Upstream must keep flush_i asserted until hold_i drops, because a flush presented under hold is not captured.
- The decoder's `default` (unknown opcode) word is all-zero, so it propagates with ex_valid=1 and no side effects.

## Timing
- Latency: 1 cycle, id_* to ex_*.
- stall_o: purely combinational from ex_* registers, id_rs/id_rt and flush_i. No register in the path.
- A load-use stall lasts exactly 1 cycle: after the bubble, ex_MemRead=0, so haz=0.
- Back-to-back flushes: one bubble per cycle; counter increments each cycle.
- Reset (asserted at any time, including mid-stall): all ex_* = 0, ex_valid=0, bubble_cnt=0. stall_o therefore =0 during and immediately after reset. Outputs update asynchronously on rst_n falling; first load occurs on the first rising edge with rst_n=1.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection, stall_o and hazard bubbles as above.
- HAZARD_DETECT_EN undefined:
  - haz is forced to 0 and stall_o is tied to 0.
  - Only flush_i and hold_i affect the stage.
  - Software must schedule a NOP after every lw whose target register is used by the next instruction.
  - bubble_cnt counts flushes only.

## Test plan
- Reset then plain flow: id = addu (RegDst=01, RegWrite=1, ALUCtrl=ADDU), id_pc4=0x0000_0004 -> next edge ex_RegWrite=1, ex_pc4=0x4, ex_valid=1; stall_o=0, bubble_cnt=0.
- Load-use: cycle N loads lw rt=8; cycle N+1 id_rs=8 -> stall_o=1 in N+1, ex_valid=0 after edge, bubble_cnt=1; N+2 stall_o=0 and the addu loads.
- No false hazard: lw rt=0 followed by id_rs=0 -> stall_o=0, no bubble. Also lw rt=8 followed by id_rs=9, id_rt=10 -> stall_o=0.
- Flush vs hazard: hazard condition present with flush_i=1 -> stall_o=0, bubble loaded, bubble_cnt +1 only once.
- hold_i=1 for 3 cycles with changing id_* and flush_i=1 -> ex_* and bubble_cnt unchanged. Release with flush_i still 1 -> bubble loaded.
- Saturation/reset: CNT_W=2, 5 consecutive flushes -> bubble_cnt stops at 3. Pull rst_n low mid-stall -> all outputs 0 immediately, without waiting for a clock edge. Without HAZARD_DETECT_EN, the load-use case gives stall_o=0 and no bubble.
